packet_disassembler: RTL

PACKET_DISASSEMBLER -- requirements
Module: packet_disassembler

---
 rtl/packet_disassembler.sv | 129 ++++++++++++
 1 files changed

// File: rtl/packet_disassembler.sv
// packet_disassembler: collects 32 data island words into an HDMI packet (header + 4 subpackets)
// Ports: clk_pixel/reset (sync, active-high); data_island_period, packet_data[8:0] in;
//        header[23:0], sub[223:0], packet_valid, packet_abort, header_ecc_error,
//        sub_ecc_error[3:0], counter[4:0] out.
// Optional BCH checking: define PACKET_DISASSEMBLER_ECC_CHECK_EN; otherwise error flags are tied to 0.
module packet_disassembler (
    input  logic         clk_pixel,
    input  logic         reset,
    input  logic         data_island_period,
    input  logic [8:0]   packet_data,
    output logic [23:0]  header,
    output logic [223:0] sub,
    output logic         packet_valid,
    output logic         packet_abort,
    output logic         header_ecc_error,
    output logic [3:0]   sub_ecc_error,
    output logic [4:0]   counter
);
    logic [4:0]   r_counter;
    logic [23:0]  r_hdr_data;
    logic [23:0]  r_header;
    logic [55:0]  r_sub_data [4];
    logic [223:0] r_sub;
    logic         r_valid;
    logic         r_abort;
    logic         w_last;
    logic         w_hdr_word;
    logic         w_sub_word;

    assign w_last     = r_counter == 5'd31;
    assign w_hdr_word = r_counter < 5'd24;
    assign w_sub_word = r_counter < 5'd28;

    always_ff @(posedge clk_pixel) begin
        r_valid <= 1'b0;
        r_abort <= 1'b0;
        if (reset) begin
            r_counter  <= '0;
            r_header   <= '0;
            r_sub      <= '0;
            r_hdr_data <= '0;
            for (int i = 0; i < 4; i++) r_sub_data[i] <= '0;
        end else if (data_island_period) begin
            r_counter <= r_counter + 5'd1;
            if (w_hdr_word) r_hdr_data[r_counter] <= packet_data[0];
            for (int i = 0; i < 4; i++) begin
                if (w_sub_word) begin
                    r_sub_data[i][{r_counter, 1'b0}] <= packet_data[1+i];
                    r_sub_data[i][{r_counter, 1'b1}] <= packet_data[5+i];
                end
            end
            if (w_last) begin
                r_header <= r_hdr_data;
                r_sub    <= {r_sub_data[3], r_sub_data[2], r_sub_data[1], r_sub_data[0]};
                r_valid  <= 1'b1;
            end
        end else if (r_counter != 5'd0) begin
            r_counter  <= '0;
            r_abort    <= 1'b1;
            r_hdr_data <= '0;
            for (int i = 0; i < 4; i++) r_sub_data[i] <= '0;
        end
    end

`ifdef PACKET_DISASSEMBLER_ECC_CHECK_EN
    logic [7:0] r_hdr_ecc;
    logic [6:0] r_hdr_rx;
    logic [7:0] r_sub_ecc [4];
    logic [5:0] r_sub_rx [4];
    logic       r_hdr_err;
    logic [3:0] r_sub_err;

    function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
        return (e >> 1) ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
    endfunction

    // The last received ECC bits arrive on word 31 itself, so the compare uses packet_data directly.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_hdr_ecc <= '0;
            r_hdr_rx  <= '0;
            r_hdr_err <= 1'b0;
            r_sub_err <= '0;
            for (int i = 0; i < 4; i++) begin
                r_sub_ecc[i] <= '0;
                r_sub_rx[i]  <= '0;
            end
        end else if (data_island_period) begin
            if (w_hdr_word) r_hdr_ecc <= ecc_step(r_hdr_ecc, packet_data[0]);
            else if (!w_last) r_hdr_rx[r_counter[2:0]] <= packet_data[0];
            for (int i = 0; i < 4; i++) begin
                if (w_sub_word) begin
                    r_sub_ecc[i] <= ecc_step(ecc_step(r_sub_ecc[i], packet_data[1+i]), packet_data[5+i]);
                end else if (!w_last) begin
                    r_sub_rx[i][{r_counter[1:0], 1'b0}] <= packet_data[1+i];
                    r_sub_rx[i][{r_counter[1:0], 1'b1}] <= packet_data[5+i];
                end
            end
            if (w_last) begin
                r_hdr_err <= r_hdr_ecc != {packet_data[0], r_hdr_rx};
                r_hdr_ecc <= '0;
                for (int i = 0; i < 4; i++) begin
                    r_sub_err[i] <= r_sub_ecc[i] != {packet_data[5+i], packet_data[1+i], r_sub_rx[i]};
                    r_sub_ecc[i] <= '0;
                end
            end
        end else if (r_counter != 5'd0) begin
            r_hdr_ecc <= '0;
            r_hdr_rx  <= '0;
            for (int i = 0; i < 4; i++) begin
                r_sub_ecc[i] <= '0;
                r_sub_rx[i]  <= '0;
            end
        end
    end

    assign header_ecc_error = r_hdr_err;
    assign sub_ecc_error    = r_sub_err;
`else
    assign header_ecc_error = 1'b0;
    assign sub_ecc_error    = 4'b0000;
`endif

    assign header       = r_header;
    assign sub          = r_sub;
    assign packet_valid = r_valid;
    assign packet_abort = r_abort;
    assign counter      = r_counter;
endmodule
